// File: rtl/cmsdk_uart_stim_pkg.sv
// Shared types and byte constants for the UART stimulus transmitter and its escape protocol.
package cmsdk_uart_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } stim_state_e;

    localparam logic [7:0] ESC         = 8'h1B;
    localparam logic [7:0] ESC_AUX     = 8'h10;
    localparam logic [7:0] ESC_DBG_ON  = 8'h11;
    localparam logic [7:0] ESC_DBG_OFF = 8'h12;
    localparam logic [7:0] EOT         = 8'h04;

endpackage

// File: rtl/cmsdk_uart_stim_fifo.sv
// Byte FIFO feeding the transmitter; head entry is read straight from the storage registers.
module cmsdk_uart_stim_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;

    // Pointer and occupancy tracking; push and pop together leave the level unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q    <= {AW{1'b0}};
            rd_q    <= {AW{1'b0}};
            level_q <= {(AW+1){1'b0}};
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == {(AW+1){1'b0}});

endmodule

// File: rtl/cmsdk_uart_stimulus.sv
// Testbench-side UART transmitter: FIFO bytes serialised as 8N1/8N2 frames on TXD.
// Optional macro UART_STIM_ESC_EN adds an AUX request that sends ESC, ESC_AUX, data ahead of FIFO bytes.
module cmsdk_uart_stimulus
    import cmsdk_uart_stim_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          TX_VALID,
    input  logic [7:0]                    TX_DATA,
    output logic                          TX_READY,
    output logic                          TXD,
    output logic                          BUSY,
`ifdef UART_STIM_ESC_EN
    input  logic                          AUX_VALID,
    input  logic [7:0]                    AUX_DATA,
    output logic                          AUX_READY,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int              LW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    stim_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic          push_s, pop_s, load_s, full_s, empty_s, baud_end_s, boundary_s;
    logic [7:0]    head_s, load_byte_s;
    logic [LW-1:0] level_s;

    assign push_s = TX_VALID & ~full_s;

    cmsdk_uart_stim_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (push_s),
        .push_data_i (TX_DATA),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .level_o     (level_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign baud_end_s = (baud_q == BAUD_LAST);
    // A new frame may only begin from IDLE or on the last cycle of the final stop bit.
    assign boundary_s = (state_q == ST_IDLE) |
                        ((state_q == ST_STOP) & baud_end_s & (stop_q == STOP_LAST));

`ifdef UART_STIM_ESC_EN
    logic       aux_pend_q, aux_pend_d;
    logic [7:0] aux_data_q, aux_data_d;
    logic [1:0] esc_cnt_q, esc_cnt_d;

    // Next-frame source: a pending escape sequence preempts the FIFO until its third frame ends.
    always_comb begin
        aux_pend_d  = aux_pend_q;
        aux_data_d  = aux_data_q;
        esc_cnt_d   = esc_cnt_q;
        load_s      = 1'b0;
        pop_s       = 1'b0;
        load_byte_s = head_s;
        if (AUX_VALID && !aux_pend_q) begin
            aux_pend_d = 1'b1;
            aux_data_d = AUX_DATA;
        end else begin
            aux_data_d = aux_data_q;
        end
        if (boundary_s) begin
            case (esc_cnt_q)
                2'd1: begin
                    load_s      = 1'b1;
                    load_byte_s = ESC_AUX;
                    esc_cnt_d   = 2'd2;
                end
                2'd2: begin
                    load_s      = 1'b1;
                    load_byte_s = aux_data_q;
                    esc_cnt_d   = 2'd3;
                end
                2'd3: begin
                    aux_pend_d = 1'b0;
                    esc_cnt_d  = 2'd0;
                    load_s     = ~empty_s;
                    pop_s      = ~empty_s;
                end
                default: begin
                    if (aux_pend_q) begin
                        load_s      = 1'b1;
                        load_byte_s = ESC;
                        esc_cnt_d   = 2'd1;
                    end else begin
                        load_s = ~empty_s;
                        pop_s  = ~empty_s;
                    end
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // Escape request state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            aux_pend_q <= 1'b0;
            aux_data_q <= 8'h00;
            esc_cnt_q  <= 2'd0;
        end else begin
            aux_pend_q <= aux_pend_d;
            aux_data_q <= aux_data_d;
            esc_cnt_q  <= esc_cnt_d;
        end
    end

    assign AUX_READY = ~aux_pend_q;
`else
    assign load_s      = boundary_s & ~empty_s;
    assign pop_s       = load_s;
    assign load_byte_s = head_s;
`endif

    // Frame sequencer next state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_START;
                    shift_d = load_byte_s;
                    txd_d   = 1'b0;
                    baud_d  = {BW{1'b0}};
                end else begin
                    txd_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_d  = {BW{1'b0}};
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (stop_q == STOP_LAST) begin
                        if (load_s) begin
                            state_d = ST_START;
                            shift_d = load_byte_s;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Frame sequencer registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign TX_READY   = ~full_s;
    assign TXD        = txd_q;
    assign FIFO_LEVEL = level_s;
    assign BUSY       = (state_q != ST_IDLE) | (level_s != {LW{1'b0}});

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Scoreboard bench: expected bytes queued on push, popped by a serial capture model decoding TXD.
`timescale 1ns/1ps
module tb_cmsdk_uart_stimulus;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_q = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [7:0] da = 8'h00, db = 8'h00;
    logic       ra, txa, busya, rb, txb, busyb;
    logic [2:0] lva, lvb;
`ifdef UART_STIM_ESC_EN
    logic       aux_v = 1'b0;
    logic [7:0] aux_d = 8'h00;
    logic       aux_r, aux_rb;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_b[$];
    int         start_cyc[$];
    string      text = "";
    logic [7:0] aux_ctrl = 8'h00;
    int         esc_st = 0;
    int         last_stop_cyc = 0;
    int         cap_pos = -1;
    logic [7:0] cap_sh = 8'h00;

    cmsdk_uart_stimulus u_dut (
        .CLK(clk), .RESET(rst), .TX_VALID(va), .TX_DATA(da), .TX_READY(ra),
        .TXD(txa), .BUSY(busya),
`ifdef UART_STIM_ESC_EN
        .AUX_VALID(aux_v), .AUX_DATA(aux_d), .AUX_READY(aux_r),
`endif
        .FIFO_LEVEL(lva)
    );

    cmsdk_uart_stimulus #(.FIFO_DEPTH(4), .BAUD_DIV(3), .STOP_BITS(2)) u_dut_slow (
        .CLK(clk), .RESET(rst), .TX_VALID(vb), .TX_DATA(db), .TX_READY(rb),
        .TXD(txb), .BUSY(busyb),
`ifdef UART_STIM_ESC_EN
        .AUX_VALID(1'b0), .AUX_DATA(8'h00), .AUX_READY(aux_rb),
`endif
        .FIFO_LEVEL(lvb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic consume(input logic [7:0] b);
        check("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) check("rx_byte", b, sb.pop_front());
        case (esc_st)
            0: if (b == 8'h1B) esc_st = 1; else text = $sformatf("%s%c", text, b);
            1: if (b == 8'h10) esc_st = 2; else esc_st = 0;
            default: begin aux_ctrl = b; esc_st = 0; end
        endcase
    endtask

    // Capture model for the BAUD_DIV=1, 8N1 instance.
    always @(negedge clk) begin
        if (rst_q) begin
            cap_pos = -1;
        end else if (cap_pos < 0) begin
            if (txa == 1'b0) begin
                cap_pos = 0;
                start_cyc.push_back(cyc);
            end
        end else if (cap_pos < 8) begin
            cap_sh[cap_pos] = txa;
            cap_pos++;
        end else begin
            check("stop_bit", txa, 1);
            last_stop_cyc = cyc;
            cap_pos = -1;
            consume(cap_sh);
        end
    end

    task automatic push_a(input logic [7:0] b);
        @(negedge clk);
        va = 1'b1;
        da = b;
        sb.push_back(b);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busya || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, (n < 2000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] rec;
        logic       expb;
        int         n;
        int         idx;
        bit         ready_now;
        bit         saw_full;

        repeat (3) @(negedge clk);
        check("rst_txd", txa, 1);
        check("rst_ready", ra, 1);
        check("rst_busy", busya, 0);
        check("rst_level", lva, 0);
        check("rst_txd_slow", txb, 1);
`ifdef UART_STIM_ESC_EN
        check("rst_aux_ready", aux_r, 1);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, exact bit timing.
        text = "";
        b = 8'h41;
        push_a(b);
        @(negedge clk);
        va = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            expb = (i == 0) ? 1'b0 : ((i < 9) ? b[i-1] : 1'b1);
            check($sformatf("t1_bit%0d", i), txa, expb);
        end
        wait_idle("t1");
        check("t1_text_A", (text == "A"), 1);

        // Back-to-back frames with no idle gap.
        text = "";
        start_cyc.delete();
        push_a(8'h48);
        push_a(8'h69);
        push_a(8'h0A);
        @(negedge clk);
        va = 1'b0;
        n = 0;
        while (busya && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t2_busy_timeout", (n < 200), 1);
        check("t2_busy_fall", cyc, last_stop_cyc + 1);
        check("t2_frames", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            check("t2_gap01", start_cyc[1] - start_cyc[0], 10);
            check("t2_gap12", start_cyc[2] - start_cyc[1], 10);
        end
        check("t2_text_Hi", (text == "Hi\n"), 1);
        wait_idle("t2");

        // Back-pressure with TX_VALID held high.
        idx = 1;
        saw_full = 1'b0;
        n = 0;
        @(negedge clk);
        va = 1'b1;
        da = 8'h01;
        while (idx <= 6 && n < 400) begin
            ready_now = ra;
            check("t3_ready_vs_level", ra, (lva < 3'd4));
            if (lva == 3'd4) saw_full = 1'b1;
            if (ready_now) sb.push_back(da);
            @(negedge clk);
            n++;
            if (ready_now) begin
                idx++;
                da = 8'(idx);
            end
        end
        va = 1'b0;
        check("t3_timeout", (n < 400), 1);
        check("t3_saw_full", saw_full, 1);
        wait_idle("t3");

        // Slow instance: BAUD_DIV=3, STOP_BITS=2, byte 0x55.
        b = 8'h55;
        sb_b.push_back(b);
        @(negedge clk);
        vb = 1'b1;
        db = b;
        @(negedge clk);
        vb = 1'b0;
        n = 0;
        while (txb !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_latency", n, 1);
        rec = 8'h00;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) @(negedge clk);
            expb = ((i / 3) == 0) ? 1'b0 : (((i / 3) <= 8) ? b[(i/3)-1] : 1'b1);
            check($sformatf("t4_cyc%0d", i), txb, expb);
            if ((i % 3) == 1 && (i / 3) >= 1 && (i / 3) <= 8) rec[(i/3)-1] = txb;
        end
        check("t4_busy_last", busyb, 1);
        @(negedge clk);
        check("t4_idle_at_33", busyb, 0);
        check("t4_byte", rec, sb_b.pop_front());

        // Reset mid-frame during data bit 3 with two bytes queued.
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        @(negedge clk);
        va = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_level_before", lva, 2);
        check("t5_bit3", txa, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("t5_txd", txa, 1);
        check("t5_level", lva, 0);
        check("t5_busy", busya, 0);
        check("t5_ready", ra, 1);
        @(negedge clk);
        text = "";
        push_a(8'h5A);
        @(negedge clk);
        va = 1'b0;
        wait_idle("t5");
        check("t5_text", (text == "Z"), 1);

`ifdef UART_STIM_ESC_EN
        // Escape sequence injected ahead of a queued byte.
        text = "";
        aux_ctrl = 8'h00;
        push_a(8'h30);
        @(negedge clk);
        va = 1'b0;
        repeat (3) @(negedge clk);
        va = 1'b1;
        da = 8'h31;
        aux_v = 1'b1;
        aux_d = 8'hA5;
        sb.push_back(8'h1B);
        sb.push_back(8'h10);
        sb.push_back(8'hA5);
        sb.push_back(8'h31);
        @(negedge clk);
        va = 1'b0;
        aux_v = 1'b0;
        check("t6_aux_busy", aux_r, 0);
        wait_idle("t6");
        check("t6_aux_ready", aux_r, 1);
        check("t6_auxctrl", aux_ctrl, 8'hA5);
        check("t6_text", (text == "01"), 1);
`endif

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
